// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip instruction
// memory with a one-cycle read latency. Port 0 is the CPU instruction master,
// port 1 is the debug/loader master. Out-of-range accesses are accepted but
// never reach the memory; out-of-range reads return zero.
//
// Handshake: a port requests when read or write is high. The request is
// taken in the same cycle in which its waitrequest is low. Every accepted
// read gets exactly one readdatavalid pulse on the issuing port one cycle
// later. Writes get no response.
module onchip_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2560,
    parameter bit ROM_MODE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   p0_address,
    input  logic                p0_read,
    input  logic                p0_write,
    input  logic [DATA_W-1:0]   p0_writedata,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    output logic                p0_waitrequest,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic                p0_readdatavalid,
    input  logic [ADDR_W-1:0]   p1_address,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W-1:0]   p1_writedata,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    output logic                p1_waitrequest,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic                p1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_debugaccess,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    output logic                mem_reset_req,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic              req0, req1;
    logic              gnt0, gnt1;
    logic              any_gnt;
    logic              sel;          // 0 = port 0 won, 1 = port 1 won
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wr;       // read+write together counts as write
    logic              in_range;
    logic              rom_drop;
    logic              issue;
    logic              rd_accept;

    logic              last_grant;
    logic              resp_valid;
    logic              resp_port;
    logic              resp_oor;
    logic [DATA_W-1:0] resp_data;

    // Arbitration, range check and memory command decode for this cycle
    always_comb begin
        req0      = p0_read | p0_write;
        req1      = p1_read | p1_write;
        gnt0      = ~reset & req0 & (~req1 | last_grant);
        gnt1      = ~reset & req1 & (~req0 | ~last_grant);
        any_gnt   = gnt0 | gnt1;
        sel       = gnt1;
        sel_addr  = sel ? p1_address : p0_address;
        sel_wr    = sel ? p1_write : p0_write;
        in_range  = {1'b0, sel_addr} < DEPTH_X;
        rom_drop  = ROM_MODE & gnt0 & p0_write;
        issue     = any_gnt & in_range & ~rom_drop;
        rd_accept = any_gnt & ~sel_wr;

        p0_waitrequest  = req0 & ~gnt0;
        p1_waitrequest  = req1 & ~gnt1;
        mem_address     = sel_addr;
        mem_writedata   = sel ? p1_writedata : p0_writedata;
        mem_byteenable  = sel ? p1_byteenable : p0_byteenable;
        mem_chipselect  = issue;
        mem_write       = issue & sel_wr;
        mem_debugaccess = issue & sel_wr;
    end

    // Round-robin pointer: remembers the last port that won a grant
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (any_gnt) begin
            last_grant <= sel;
        end
    end

    // Read response stage: tracks which port issued the read and whether it
    // was out of range, aligned with the memory's one-cycle q latency
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_port  <= 1'b0;
            resp_oor   <= 1'b0;
        end else begin
            resp_valid <= rd_accept;
            resp_port  <= sel;
            resp_oor   <= ~in_range;
        end
    end

    // A reset arriving right after an accept must kill that response too
    assign resp_data        = resp_oor ? '0 : mem_readdata;
    assign p0_readdata      = resp_data;
    assign p1_readdata      = resp_data;
    assign p0_readdatavalid = resp_valid & ~reset & ~resp_port;
    assign p1_readdatavalid = resp_valid & ~reset & resp_port;

    assign mem_clken     = 1'b1;
    assign mem_reset_req = reset;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural model of the
// single-port memory (byte-enabled writes, one-cycle registered q).
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] p0_address, p1_address;
  logic        p0_read, p1_read, p0_write, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [11:0] mem_address;
  logic        mem_chipselect, mem_write, mem_debugaccess;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_clken, mem_reset_req;
  logic [31:0] mem_readdata;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .p0_address       (p0_address),
    .p0_read          (p0_read),
    .p0_write         (p0_write),
    .p0_writedata     (p0_writedata),
    .p0_byteenable    (p0_byteenable),
    .p0_waitrequest   (p0_waitrequest),
    .p0_readdata      (p0_readdata),
    .p0_readdatavalid (p0_readdatavalid),
    .p1_address       (p1_address),
    .p1_read          (p1_read),
    .p1_write         (p1_write),
    .p1_writedata     (p1_writedata),
    .p1_byteenable    (p1_byteenable),
    .p1_waitrequest   (p1_waitrequest),
    .p1_readdata      (p1_readdata),
    .p1_readdatavalid (p1_readdatavalid),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_debugaccess  (mem_debugaccess),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_clken        (mem_clken),
    .mem_reset_req    (mem_reset_req),
    .mem_readdata     (mem_readdata)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_model [0:2559];

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      mem_readdata <= mem_model[mem_address];
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    p0_read = 0; p0_write = 0; p0_address = '0; p0_writedata = '0; p0_byteenable = 4'hF;
    p1_read = 0; p1_write = 0; p1_address = '0; p1_writedata = '0; p1_byteenable = 4'hF;
  endtask

  // advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // sample point in the middle of the current cycle
  task automatic mid();
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 2560; i++) mem_model[i] = 32'h0;
    mem_model[12'h005] = 32'h12345678;
    mem_model[12'h006] = 32'h66666666;
    mem_model[12'h100] = 32'h0;
    mem_readdata = 32'h0;

    // reset with a request pending: no grant, waitrequest follows request
    reset = 1'b1;
    idle_all();
    p1_read = 1'b1; p1_address = 12'h006;
    next_cycle();
    next_cycle();
    mid();
    chk("rst_p1_wait", {31'b0, p1_waitrequest}, 32'd1);
    chk("rst_p0_wait_idle", {31'b0, p0_waitrequest}, 32'd0);
    chk("rst_cs", {31'b0, mem_chipselect}, 32'd0);
    chk("rst_wr", {31'b0, mem_write}, 32'd0);
    chk("rst_rdv", {30'b0, p0_readdatavalid, p1_readdatavalid}, 32'd0);
    chk("rst_req", {31'b0, mem_reset_req}, 32'd1);
    chk("clken", {31'b0, mem_clken}, 32'd1);
    next_cycle();
    reset = 1'b0;
    idle_all();
    mid();
    chk("idle_wait", {30'b0, p0_waitrequest, p1_waitrequest}, 32'd0);
    chk("idle_reset_req", {31'b0, mem_reset_req}, 32'd0);

    // single p0 read of 0x005
    next_cycle();
    p0_read = 1'b1; p0_address = 12'h005;
    mid();
    chk("t1_p0_wait", {31'b0, p0_waitrequest}, 32'd0);
    chk("t1_cs", {31'b0, mem_chipselect}, 32'd1);
    chk("t1_addr", {20'b0, mem_address}, 32'h005);
    chk("t1_wr", {31'b0, mem_write}, 32'd0);
    next_cycle();
    idle_all();
    mid();
    chk("t1_p0_rdv", {31'b0, p0_readdatavalid}, 32'd1);
    chk("t1_p0_data", p0_readdata, 32'h12345678);
    chk("t1_p1_rdv", {31'b0, p1_readdatavalid}, 32'd0);

    // reset pulse so the contention run starts from a fresh pointer
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;

    // continuous contention: P0,P1,P0,P1,P0,P1
    p0_read = 1'b1; p0_address = 12'h005;
    p1_read = 1'b1; p1_address = 12'h006;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk($sformatf("c%0d_p0_wait", k), {31'b0, p0_waitrequest}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d_p1_wait", k), {31'b0, p1_waitrequest}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d_addr", k), {20'b0, mem_address}, (k % 2 == 0) ? 32'h005 : 32'h006);
      if (k > 0) begin
        chk($sformatf("c%0d_p0_rdv", k), {31'b0, p0_readdatavalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk($sformatf("c%0d_p1_rdv", k), {31'b0, p1_readdatavalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("c%0d_data", k), p0_readdata, (k % 2 == 1) ? 32'h12345678 : 32'h66666666);
      end
      next_cycle();
    end
    idle_all();
    mid();
    chk("c6_p1_rdv", {31'b0, p1_readdatavalid}, 32'd1);
    chk("c6_p0_rdv", {31'b0, p0_readdatavalid}, 32'd0);
    chk("c6_data", p1_readdata, 32'h66666666);

    // p1 write then read back 0x100
    next_cycle();
    p1_write = 1'b1; p1_address = 12'h100; p1_writedata = 32'hCAFEF00D; p1_byteenable = 4'hF;
    mid();
    chk("w_p1_wait", {31'b0, p1_waitrequest}, 32'd0);
    chk("w_cs", {31'b0, mem_chipselect}, 32'd1);
    chk("w_wr", {31'b0, mem_write}, 32'd1);
    chk("w_dbg", {31'b0, mem_debugaccess}, 32'd1);
    chk("w_wdata", mem_writedata, 32'hCAFEF00D);
    chk("w_be", {28'b0, mem_byteenable}, 32'hF);
    next_cycle();
    p1_write = 1'b0; p1_read = 1'b1;
    mid();
    chk("w_no_resp", {30'b0, p0_readdatavalid, p1_readdatavalid}, 32'd0);
    chk("r_wr", {31'b0, mem_write}, 32'd0);
    chk("r_dbg", {31'b0, mem_debugaccess}, 32'd0);
    next_cycle();
    idle_all();
    mid();
    chk("r_p1_rdv", {31'b0, p1_readdatavalid}, 32'd1);
    chk("r_p1_data", p1_readdata, 32'hCAFEF00D);

    // ROM mode: p0 write accepted but not issued
    next_cycle();
    p0_write = 1'b1; p0_address = 12'h100; p0_writedata = 32'hFFFFFFFF; p0_byteenable = 4'hF;
    mid();
    chk("rom_p0_wait", {31'b0, p0_waitrequest}, 32'd0);
    chk("rom_cs", {31'b0, mem_chipselect}, 32'd0);
    chk("rom_wr", {31'b0, mem_write}, 32'd0);
    next_cycle();
    idle_all();
    p1_read = 1'b1; p1_address = 12'h100;
    mid();
    chk("rom_no_resp", {31'b0, p0_readdatavalid}, 32'd0);
    next_cycle();
    idle_all();
    mid();
    chk("rom_rdv", {31'b0, p1_readdatavalid}, 32'd1);
    chk("rom_old_data", p1_readdata, 32'hCAFEF00D);

    // out of range: p0 reads 0xA00, p1 writes 0xFFF (tie, pointer=1 -> p0 first)
    next_cycle();
    p0_read = 1'b1; p0_address = 12'hA00;
    p1_write = 1'b1; p1_address = 12'hFFF; p1_writedata = 32'h00000055;
    mid();
    chk("oor_p0_wait", {31'b0, p0_waitrequest}, 32'd0);
    chk("oor_p1_wait", {31'b0, p1_waitrequest}, 32'd1);
    chk("oor_cs0", {31'b0, mem_chipselect}, 32'd0);
    next_cycle();
    p0_read = 1'b0;
    mid();
    chk("oor_p0_rdv", {31'b0, p0_readdatavalid}, 32'd1);
    chk("oor_p0_data", p0_readdata, 32'h0);
    chk("oor_p1_wait2", {31'b0, p1_waitrequest}, 32'd0);
    chk("oor_cs1", {31'b0, mem_chipselect}, 32'd0);
    chk("oor_wr1", {31'b0, mem_write}, 32'd0);
    next_cycle();
    idle_all();
    mid();
    chk("oor_no_resp", {30'b0, p0_readdatavalid, p1_readdatavalid}, 32'd0);

    // read+write together on p1 behaves as a write (no response)
    next_cycle();
    p1_read = 1'b1; p1_write = 1'b1; p1_address = 12'h101; p1_writedata = 32'h00000BAD;
    mid();
    chk("rw_wr", {31'b0, mem_write}, 32'd1);
    next_cycle();
    idle_all();
    mid();
    chk("rw_no_resp", {31'b0, p1_readdatavalid}, 32'd0);

    // read accepted, then reset next cycle suppresses its response
    next_cycle();
    p0_read = 1'b1; p0_address = 12'h005;
    mid();
    chk("ra_p0_wait", {31'b0, p0_waitrequest}, 32'd0);
    next_cycle();
    idle_all();
    reset = 1'b1;
    mid();
    chk("ra_rdv_supp", {31'b0, p0_readdatavalid}, 32'd0);
    chk("ra_reset_req", {31'b0, mem_reset_req}, 32'd1);
    next_cycle();
    reset = 1'b0;
    p0_read = 1'b1; p0_address = 12'h005;
    p1_read = 1'b1; p1_address = 12'h006;
    mid();
    chk("ra_tie_p0_wait", {31'b0, p0_waitrequest}, 32'd0);
    chk("ra_tie_p1_wait", {31'b0, p1_waitrequest}, 32'd1);
    chk("ra_tie_addr", {20'b0, mem_address}, 32'h005);
    chk("ra_rdv_after", {30'b0, p0_readdatavalid, p1_readdatavalid}, 32'd0);
    next_cycle();
    idle_all();
    mid();
    chk("ra_tie_rdv", {31'b0, p0_readdatavalid}, 32'd1);
    chk("ra_tie_data", p0_readdata, 32'h12345678);

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
